// File: rtl/cpu8085_pkg.sv
// Shared definitions for the 8085-style external bus cycle logic: machine-cycle
// states, read/write and IO/memory encodings, and a small state-decode helper.
package cpu8085_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4
    } bus_state_e;

    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;
    localparam logic IO_CYCLE  = 1'b1;
    localparam logic MEM_CYCLE = 1'b0;

    // States in which the read or write strobe is asserted.
    function automatic logic is_strobe_state(input bus_state_e s);
        return (s == T2) || (s == TW) || (s == T3);
    endfunction

endpackage

// File: rtl/ad_pin_drv.sv
// Tri-state driver for the multiplexed AD pins; the FSM only sees oe/dout/din.
module ad_pin_drv #(
    parameter int DATA_W = 8
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] pad
);

    assign pad = oe ? dout : {DATA_W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085-style external bus cycle controller (T1/T2/TW/T3) with registered pin outputs.
// Optional wait-state timeout is enabled by defining WAIT_TIMEOUT_EN.
module bus_cycle_ctrl
    import cpu8085_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic              io_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ready,
    inout  wire  [DATA_W-1:0] ad,
    output logic [ADDR_W-9:0] a_hi,
    output logic              ale,
    output logic              rd_n,
    output logic              wr_n,
    output logic              io_m,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    bus_state_e        state_q, state_d;
    logic              rw_q, rw_d;
    logic              io_q, io_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-9:0] a_hi_q, a_hi_d;
    logic              ale_q, ale_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              io_m_q, io_m_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ad_oe_q, ad_oe_d;
    logic [DATA_W-1:0] ad_dout_q, ad_dout_d;
    logic [DATA_W-1:0] ad_din;
    logic              strobe_d;

`ifdef WAIT_TIMEOUT_EN
    localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
`endif

    ad_pin_drv #(.DATA_W(DATA_W)) u_ad_drv (
        .oe   (ad_oe_q),
        .dout (ad_dout_q),
        .din  (ad_din),
        .pad  (ad)
    );

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        io_d    = io_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
`ifdef WAIT_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    io_d    = io_sel;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = T1;
                end
            end
            T1: state_d = T2;
            T2: begin
                state_d = ready ? T3 : TW;
`ifdef WAIT_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            TW: begin
                if (ready) begin
                    state_d = T3;
                end else begin
`ifdef WAIT_TIMEOUT_EN
                    // This TW was the last one allowed: abort without done or rdata update.
                    if (wait_cnt_q >= WCNT_W'(MAX_WAIT - 1)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
`endif
                end
            end
            T3: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (rw_q == RW_READ) begin
                    rdata_d = ad_din;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin outputs are decoded from the next state so they change with the state flop.
        strobe_d  = is_strobe_state(state_d);
        busy_d    = (state_d != IDLE);
        ale_d     = (state_d == T1);
        rd_n_d    = !(strobe_d && (rw_d == RW_READ));
        wr_n_d    = !(strobe_d && (rw_d == RW_WRITE));
        io_m_d    = busy_d ? io_d : MEM_CYCLE;
        a_hi_d    = busy_d ? addr_d[ADDR_W-1:8] : '0;
        ad_oe_d   = (state_d == T1) || (strobe_d && (rw_d == RW_WRITE));
        ad_dout_d = (state_d == T1) ? addr_d[DATA_W-1:0] : wdata_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rw_q      <= RW_READ;
            io_q      <= MEM_CYCLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            a_hi_q    <= '0;
            ale_q     <= 1'b0;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            io_m_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ad_oe_q   <= 1'b0;
            ad_dout_q <= '0;
`ifdef WAIT_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            io_q      <= io_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            a_hi_q    <= a_hi_d;
            ale_q     <= ale_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            io_m_q    <= io_m_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ad_oe_q   <= ad_oe_d;
            ad_dout_q <= ad_dout_d;
`ifdef WAIT_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign a_hi  = a_hi_q;
    assign ale   = ale_q;
    assign rd_n  = rd_n_q;
    assign wr_n  = wr_n_q;
    assign io_m  = io_m_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
`ifdef WAIT_TIMEOUT_EN
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed machine cycles plus randomized
// transactions checked cycle-by-cycle against a timeline model of the bus cycle.
module tb_bus_cycle_ctrl;

`ifdef WAIT_TIMEOUT_EN
    localparam int MW = 4;
`else
    localparam int MW = 15;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        rw;
    logic        io_sel;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    wire  [7:0]  ad;
    logic [7:0]  a_hi;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        io_m;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0]  mem_byte;
    logic [7:0]  exp_rdata;
    int          n_checks;
    int          n_fail;
    int          n_txn;

    always #5 clk = ~clk;

    // Memory/IO device model: drives the byte back whenever the read strobe is low.
    assign ad = (rd_n == 1'b0) ? mem_byte : 8'hzz;

    bus_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(MW)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .rw     (rw),
        .io_sel (io_sel),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .ad     (ad),
        .a_hi   (a_hi),
        .ale    (ale),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .io_m   (io_m),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_pins(input string tag, input logic e_ale, input logic e_busy,
                               input logic e_rd_n, input logic e_wr_n, input logic e_done,
                               input logic e_oe, input logic e_io_m, input logic [7:0] e_a_hi);
        check({tag, " ale"},   32'(ale),   32'(e_ale));
        check({tag, " busy"},  32'(busy),  32'(e_busy));
        check({tag, " rd_n"},  32'(rd_n),  32'(e_rd_n));
        check({tag, " wr_n"},  32'(wr_n),  32'(e_wr_n));
        check({tag, " done"},  32'(done),  32'(e_done));
        check({tag, " ad_oe"}, 32'(dut.ad_oe_q), 32'(e_oe));
        check({tag, " io_m"},  32'(io_m),  32'(e_io_m));
        check({tag, " a_hi"},  32'(a_hi),  32'(e_a_hi));
        check({tag, " err"},   32'(err),   32'h0);
        check({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
    endtask

    // One complete machine cycle. The model timeline: cycle 1 is T1, cycles 2..3+waits
    // carry the strobe (T2, waits x TW, T3), and cycle 4+waits is the done cycle.
    task automatic run_txn(input string name, input logic t_rw, input logic t_io,
                           input logic [15:0] t_addr, input logic [7:0] t_wdata,
                           input logic [7:0] t_mem, input int t_waits, input bit t_hold);
        int    total;
        string tag;
        total    = t_waits + 4;
        req      = 1'b1;
        rw       = t_rw;
        io_sel   = t_io;
        addr     = t_addr;
        wdata    = t_wdata;
        mem_byte = t_mem;
        ready    = 1'($urandom);
        for (int k = 1; k <= total; k++) begin
            @(posedge clk);
            #1;
            req    = (k == total) ? t_hold : (t_hold ? 1'b1 : 1'($urandom));
            rw     = 1'($urandom);
            io_sel = 1'($urandom);
            addr   = 16'($urandom);
            wdata  = 8'($urandom);
            if (k >= 2 && k <= 1 + t_waits)
                ready = 1'b0;
            else if (k == 2 + t_waits)
                ready = 1'b1;
            else
                ready = 1'($urandom);
            @(negedge clk);
            tag = $sformatf("%s c%0d", name, k);
            if (k == 1) begin
                expect_pins(tag, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, t_io, t_addr[15:8]);
                check({tag, " ad_addr"}, 32'(ad), 32'(t_addr[7:0]));
            end else if (k < total) begin
                expect_pins(tag, 1'b0, 1'b1, !t_rw, t_rw, 1'b0, !t_rw, t_io, t_addr[15:8]);
                if (!t_rw)
                    check({tag, " ad_wdata"}, 32'(ad), 32'(t_wdata));
            end else begin
                if (t_rw)
                    exp_rdata = t_mem;
                expect_pins(tag, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            end
        end
        n_txn++;
        $display("txn %0d %s %s %s addr=%h wdata=%h mem=%h waits=%0d rdata=%h",
                 n_txn, name, t_rw ? "RD" : "WR", t_io ? "IO" : "MEM",
                 t_addr, t_wdata, t_mem, t_waits, rdata);
    endtask

    task automatic idle_cycles(input int n);
        req = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            ready = 1'($urandom);
            @(negedge clk);
            expect_pins("idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic reset_during_write();
        req    = 1'b1;
        rw     = 1'b0;
        io_sel = 1'b0;
        addr   = 16'h1234;
        wdata  = 8'hC3;
        ready  = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("rst_wr T1 ale", 32'(ale), 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_wr T2 wr_n", 32'(wr_n), 32'h0);
        check("rst_wr T2 ad", 32'(ad), 32'hC3);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        exp_rdata = 8'h00;
        expect_pins("rst_wr after", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wr no done", 32'(done), 32'h0);
        check("rst_wr busy", 32'(busy), 32'h0);
        n_txn++;
        $display("txn %0d reset during write T2 aborted cycle", n_txn);
    endtask

`ifdef WAIT_TIMEOUT_EN
    // Model: T1, T2, then MW wait states with READY low, then an idle cycle with err.
    task automatic timeout_read();
        string tag;
        req      = 1'b1;
        rw       = 1'b1;
        io_sel   = 1'b0;
        addr     = 16'h4242;
        mem_byte = 8'h99;
        ready    = 1'b0;
        for (int k = 1; k <= MW + 4; k++) begin
            @(posedge clk);
            #1;
            req   = 1'b0;
            ready = 1'b0;
            @(negedge clk);
            tag = $sformatf("timeout c%0d", k);
            check({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
            check({tag, " done"}, 32'(done), 32'h0);
            if (k <= MW + 2) begin
                check({tag, " busy"}, 32'(busy), 32'h1);
                check({tag, " err"}, 32'(err), 32'h0);
                if (k >= 2)
                    check({tag, " rd_n"}, 32'(rd_n), 32'h0);
            end else if (k == MW + 3) begin
                check({tag, " err"}, 32'(err), 32'h1);
                check({tag, " busy"}, 32'(busy), 32'h0);
                check({tag, " rd_n"}, 32'(rd_n), 32'h1);
                check({tag, " ad_oe"}, 32'(dut.ad_oe_q), 32'h0);
            end else begin
                check({tag, " err"}, 32'(err), 32'h0);
            end
        end
        n_txn++;
        $display("txn %0d timeout read after %0d wait states", n_txn, MW);
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_txn     = 0;
        exp_rdata = 8'h00;
        reset     = 1'b1;
        req       = 1'b0;
        rw        = 1'b0;
        io_sel    = 1'b0;
        addr      = 16'h0000;
        wdata     = 8'h00;
        ready     = 1'b1;
        mem_byte  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        expect_pins("reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;

        run_txn("rd_basic", 1'b1, 1'b0, 16'h20A5, 8'h00, 8'h3C, 0, 1'b0);
        idle_cycles(1);
        run_txn("wr_io", 1'b0, 1'b1, 16'h8001, 8'h5A, 8'h00, 0, 1'b0);
        idle_cycles(1);
        run_txn("rd_wait3", 1'b1, 1'b0, 16'h0F0F, 8'h00, 8'hA7, 3, 1'b0);
        idle_cycles(1);
        reset_during_write();
`ifdef WAIT_TIMEOUT_EN
        run_txn("rd_pre_to", 1'b1, 1'b0, 16'h1111, 8'h00, 8'h6E, 1, 1'b0);
        timeout_read();
        idle_cycles(1);
`endif
        run_txn("b2b_first", 1'b1, 1'b0, 16'h3001, 8'h00, 8'h11, 0, 1'b1);
        run_txn("b2b_second", 1'b1, 1'b0, 16'h3002, 8'h00, 8'h22, 0, 1'b0);
        idle_cycles(1);

        for (int i = 0; i < 24; i++) begin
            run_txn($sformatf("rand%0d", i), 1'($urandom), 1'($urandom), 16'($urandom),
                    8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
